pio_in_edge_irq: RTL and testbench

- Parametrised successor to the fixed 16-bit read-only input PIO.
- Avalon-MM slave that does the following:
  - synchronises a DATA_WIDTH-bit external input bus;
  - exposes the input value;
  - latches per-bit edge events into a capture register;
  - raises a maskable level interrupt.
- Sits between board-level signals (keys, switches, camera start/status strobes) and the Nios II / HPS bus fabric.

---
 rtl/pio_in_edge_irq.sv | 121 ++++++++++++
 tb/tb_pio_in_edge_irq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture and a maskable level interrupt.
// Optional per-bit glitch filter is built when PIO_GLITCH_FILTER_EN is defined.
module pio_in_edge_irq #(
  parameter int DATA_WIDTH    = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_TYPE     = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [SYNC_STAGES*DATA_WIDTH-1:0] sync_chain;
  logic [DATA_WIDTH-1:0]             sync_in;
  logic [DATA_WIDTH-1:0]             src;
  logic [DATA_WIDTH-1:0]             prev;
  logic [DATA_WIDTH-1:0]             rise;
  logic [DATA_WIDTH-1:0]             fall;
  logic [DATA_WIDTH-1:0]             edge_event;
  logic [DATA_WIDTH-1:0]             irqmask;
  logic [DATA_WIDTH-1:0]             edgecapture;
  logic [DATA_WIDTH-1:0]             clr;
  logic [31:0]                       read_mux;
  logic                              wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[(SYNC_STAGES-1)*DATA_WIDTH-1:0], in_port};
    end
  end

  assign sync_in = sync_chain[SYNC_STAGES*DATA_WIDTH-1 -: DATA_WIDTH];

`ifdef PIO_GLITCH_FILTER_EN
  logic [DATA_WIDTH-1:0] filt;

  // Each bit only follows sync_in after it has held the new level for FILTER_CYCLES clocks.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_filt
    logic [7:0] cnt;
    logic       filt_bit;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= 8'd0;
        filt_bit <= 1'b0;
      end else if (sync_in[gi] == filt_bit) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(FILTER_CYCLES - 1)) begin
        filt_bit <= sync_in[gi];
        cnt      <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end

    assign filt[gi] = filt_bit;
  end

  assign src = filt;
`else
  assign src = sync_in;
`endif

  assign rise = src & ~prev;
  assign fall = ~src & prev;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_event = rise;
      1:       edge_event = fall;
      default: edge_event = rise | fall;
    endcase
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux[DATA_WIDTH-1:0] = src;
      2'd2:    read_mux[DATA_WIDTH-1:0] = irqmask;
      2'd3:    read_mux[DATA_WIDTH-1:0] = edgecapture;
      default: read_mux = '0;
    endcase
  end

  // Reads see pre-write state, so a same-cycle W1C read returns the old capture value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      prev        <= src;
      edgecapture <= edge_event | (edgecapture & ~clr);
      readdata    <= read_mux;
      irq         <= |(edgecapture & irqmask);
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[DATA_WIDTH-1:0];
      end
    end
  end

  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:DATA_WIDTH];
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: a cycle-indexed history model checked every cycle,
// plus hand-computed expectations. Honours PIO_GLITCH_FILTER_EN when defined.
module tb_pio_in_edge_irq;

  localparam int DW = 16;
  localparam int S  = 2;
  localparam int ET = 0;
  localparam int FC = 4;
`ifdef PIO_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT = S + 1 + (FILT ? FC : 0);
  localparam int HN  = 8192;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic          irq;

  int tests = 0;
  int fails = 0;

  pio_in_edge_irq #(
    .DATA_WIDTH(DW), .SYNC_STAGES(S), .EDGE_TYPE(ET), .FILTER_CYCLES(FC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every edge since reset is indexed by n; values "after edge k" live at index k.
  logic [DW-1:0] smp [HN];
  logic [DW-1:0] syn [HN];
  logic [DW-1:0] srcv[HN];
  int            n = 0;
  logic [DW-1:0] m_cap = '0;
  logic [DW-1:0] m_mask = '0;
  logic [31:0]   m_rd = '0;
  logic          m_irq = 1'b0;

  function automatic logic [DW-1:0] syn_at(input int k);
    return (k >= 0) ? syn[k] : '0;
  endfunction

  function automatic logic [DW-1:0] src_at(input int k);
    return (k >= 0) ? srcv[k] : '0;
  endfunction

  function automatic logic [DW-1:0] syn_calc();
    return (n - S + 1 >= 0) ? smp[n-S+1] : '0;
  endfunction

  function automatic logic [DW-1:0] src_calc();
    logic [DW-1:0] f;
    logic [DW-1:0] s;
    logic          held;
    if (!FILT) return syn_calc();
    f = src_at(n - 1);
    for (int b = 0; b < DW; b++) begin
      held = 1'b1;
      for (int j = 1; j <= FC; j++) begin
        s = syn_at(n - j);
        if (s[b] == f[b]) held = 1'b0;
      end
      if (held) f[b] = ~f[b];
    end
    return f;
  endfunction

  function automatic logic [DW-1:0] edge_events();
    logic [DW-1:0] cur;
    logic [DW-1:0] old;
    cur = src_at(n - 1);
    old = src_at(n - 2);
    if (ET == 0) return cur & ~old;
    if (ET == 1) return ~cur & old;
    return cur ^ old;
  endfunction

  function automatic logic [DW-1:0] model_clear();
    if (chipselect && !write_n && address == 2'd3) return writedata[DW-1:0];
    return '0;
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] r;
    r = 32'd0;
    if (address == 2'd0) r[DW-1:0] = src_at(n - 1);
    if (address == 2'd2) r[DW-1:0] = m_mask;
    if (address == 2'd3) r[DW-1:0] = m_cap;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n      <= 0;
      m_cap  <= '0;
      m_mask <= '0;
      m_rd   <= '0;
      m_irq  <= 1'b0;
    end else if (n < HN) begin
      m_rd  <= model_read();
      m_irq <= |(m_cap & m_mask);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[DW-1:0];
      m_cap   <= edge_events() | (m_cap & ~model_clear());
      smp[n]  <= in_port;
      syn[n]  <= syn_calc();
      srcv[n] <= src_calc();
      n       <= n + 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("[TB] write addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
    $display("[TB] read  addr=%0d data=%h", a, d);
  endtask

  logic [31:0] d;
  int          k;

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = '0;
    cyc(3);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // DATA path value and latency
    address = 2'd0;
    in_port = 16'hA5C3;
    k = 0;
    while (readdata !== 32'h0000A5C3 && k < 30) begin
      @(negedge clk);
      k++;
    end
    $display("[TB] data visible after %0d clocks", k);
    check("data_latency", k, LAT);
    check("data_value", readdata, 32'h0000A5C3);
    check("data_irq_masked", {31'd0, irq}, 32'd0);
    wr(2'd3, 32'hFFFF);
    in_port = '0;
    cyc(LAT + 2);
    wr(2'd3, 32'hFFFF);
    rd(2'd3, d);
    check("capture_cleared", d, 32'd0);

    // rising pulse on bit 0 with mask 1
    wr(2'd2, 32'h1);
    in_port = 16'h0001;
    cyc(FC + 2);
    in_port = '0;
    cyc(LAT + 2);
    rd(2'd3, d);
    check("capture_bit0", d, 32'h1);
    check("irq_bit0", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1);
    check("irq_after_clear_edge", {31'd0, irq}, 32'd1);
    cyc(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd(2'd3, d);
    check("capture_bit0_cleared", d, 32'd0);
    wr(2'd2, 32'h0);

    // edge and W1C on bit 3 in the same cycle
    in_port = 16'h0018;
    cyc(LAT + 2);
    in_port = '0;
    cyc(LAT + 2);
    rd(2'd3, d);
    check("capture_0x18", d, 32'h18);
    in_port = 16'h0008;
    cyc(LAT - 1);
    address    = 2'd3;
    writedata  = 32'h18;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("[TB] write addr=3 data=00000018 (coincident edge on bit 3)");
    check("w1c_read_old", readdata, 32'h18);
    @(negedge clk);
    check("set_wins", readdata, 32'h08);

    // mask-driven irq timing with capture 0x10
    wr(2'd3, 32'hFFFF);
    in_port = 16'h0018;
    cyc(LAT + 2);
    rd(2'd3, d);
    check("capture_0x10", d, 32'h10);
    check("irq_unmasked_off", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h10);
    check("irq_mask_lag", {31'd0, irq}, 32'd0);
    cyc(1);
    check("irq_mask_on", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h0);
    check("irq_unmask_lag", {31'd0, irq}, 32'd1);
    cyc(1);
    check("irq_unmask_off", {31'd0, irq}, 32'd0);

    // asynchronous reset with full capture and irq asserted
    wr(2'd2, 32'hFFFF);
    in_port = '0;
    cyc(LAT + 2);
    wr(2'd3, 32'hFFFF);
    in_port = 16'hFFFF;
    cyc(LAT + 2);
    address = 2'd3;
    cyc(2);
    check("pre_reset_capture", readdata, 32'hFFFF);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    in_port = '0;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 32'd0);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd2, d);
    check("reset_mask", d, 32'd0);
    rd(2'd3, d);
    check("reset_capture", d, 32'd0);

`ifdef PIO_GLITCH_FILTER_EN
    // short pulse is filtered, FC-cycle pulse is captured
    in_port = 16'h0002;
    cyc(FC - 1);
    in_port = '0;
    cyc(LAT + 4);
    rd(2'd3, d);
    check("filter_short_pulse", d, 32'd0);
    in_port = 16'h0002;
    cyc(FC);
    in_port = '0;
    cyc(LAT + 4);
    rd(2'd3, d);
    check("filter_long_pulse", d, 32'h2);
`else
    // a single-cycle pulse is captured without the filter
    in_port = 16'h0002;
    cyc(1);
    in_port = '0;
    cyc(LAT + 4);
    rd(2'd3, d);
    check("short_pulse_captured", d, 32'h2);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
